fetch_db_rot: RTL
=================

FETCH_DB_ROT -- requirements
Module: fetch_db_rot

Interface
REQ-001 Parameter PIXEL_WIDTH, default 8: bits per pixel.
REQ-002 Parameter NUM_BUF, default 3, legal 2..4: number of rotating deblock output buffers.
REQ-003 Parameter WADDR_W, default 6: write-word address width per buffer; each buffer holds 2^WADDR_W words of 16 pixels.
REQ-004 Parameter REF_AW, default 5: ref bank address width; each bank holds 2^REF_AW words of 16 pixels.
REQ-005 Port list, one per line (name, direction, width, meaning); CW = clog2(NUM_BUF+1):
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous reset, active-high.
start_i  in  1  pipeline start pulse; toggles the ref bank.
db_wen_i  in  1  deblock 4x4 write enable.
db_waddr_i  in  WADDR_W  write word address.
db_wprev_i  in  1  write targets the previous buffer.
db_wdata_i  in  16*PIXEL_WIDTH  write data.
db_done_i  in  1  pulse; current write buffer complete.
db_full_o  out  1  all buffers occupied.
st_en_i  in  1  store read enable.
st_addr_i  in  WADDR_W-1  store read address (32-pixel word).
st_data_o  out  32*PIXEL_WIDTH  store read data.
st_valid_o  out  1  st_data_o updated this cycle.
st_ready_o  out  1  level; at least one completed buffer.
st_done_i  in  1  pulse; oldest buffer drained.
count_o  out  CW  completed-buffer count.
err_o  out  2  sticky; bit0 overflow, bit1 underflow.
ref_wen_i  in  1  ref write enable.
ref_waddr_i  in  REF_AW  ref write address.
ref_wdata_i  in  16*PIXEL_WIDTH  ref write data.
ref_ren_i  in  1  ref read enable.
ref_raddr_i  in  REF_AW  ref read address.
ref_lane_i  in  2  4-pixel lane select.
ref_rdata_o  out  4*PIXEL_WIDTH  ref read lane data.

Function
REQ-006 Internal wr_ptr and rd_ptr, each modulo NUM_BUF, wrapping from NUM_BUF-1 to 0; count 0..NUM_BUF.
REQ-007 db_done_i is accepted when count<NUM_BUF, or when st_done_i is accepted in the same cycle; on acceptance wr_ptr advances by one.
REQ-008 A db_done_i that is not accepted is dropped and sets err_o[0].
REQ-009 st_done_i is accepted only when count>0; on acceptance rd_ptr advances by one.
REQ-010 A st_done_i that is not accepted is dropped and sets err_o[1].
REQ-011 count next-state: +1 for done alone, -1 for store_done alone, unchanged for both or neither.
REQ-012 db_full_o = (count==NUM_BUF); st_ready_o = (count>0); count_o = count. All three are registered-state derived, with no input bypass.
REQ-013 Write target buffer: wr_ptr when db_wprev_i=0; (wr_ptr-1) mod NUM_BUF when db_wprev_i=1.
REQ-014 A write with db_wprev_i=0 while db_full_o=1 is dropped without affecting err_o; its buffer holds undrained data.
REQ-015 Write and db_done_i in the same cycle: the write lands in the pre-advance buffer.
REQ-016 Store read: st_en_i reads buffer rd_ptr; st_data_o = {word[2*st_addr_i], word[2*st_addr_i+1]}, even word in the MSBs.
REQ-017 Read latency is 1 cycle. st_valid_o is asserted the cycle after st_en_i only if st_ready_o was 1 at issue. st_data_o holds its last value otherwise.
REQ-018 st_en_i together with st_done_i reads the pre-advance buffer.
REQ-019 Ref path: two banks, register ref_sel. Writes go to bank ref_sel; reads come from bank ~ref_sel; start_i toggles ref_sel.
REQ-020 start_i coincident with a ref write or read uses the pre-toggle ref_sel.
REQ-021 Ref read latency is 1 cycle; ref_lane_i is registered with the read. Lane 0 = bits [16*PW-1:12*PW], lane 3 = bits [4*PW-1:0]. ref_rdata_o holds its value when no read is issued.
REQ-022 Same-address same-bank read/write cannot occur, because the bank split makes it impossible.

Reset
REQ-023 rst asserted asynchronously clears wr_ptr, rd_ptr, count, err_o, ref_sel, st_data_o, st_valid_o and ref_rdata_o to 0. db_full_o=0 and st_ready_o=0 follow.
REQ-024 Memory contents are not reset. rst mid-operation abandons all buffer occupancy, and reads after reset return stale data.
REQ-025 Operation resumes on the first rising clk edge after rst deasserts.

Verification
REQ-026 NUM_BUF=3: fill buffer 0 (word 0=A, word 1=B), db_done; st_en addr 0 -> next cycle st_valid=1, st_data={A,B}; count_o=1.
REQ-027 Three db_done without store -> db_full_o=1, count_o=3. A fourth db_done -> err_o=2'b01, wr_ptr unchanged. A simultaneous db_done+st_done while full -> count_o stays 3, both pointers advance.
REQ-028 st_done at count 0 -> err_o[1]=1, rd_ptr stays 0. After 3 accepted done/st_done pairs, both pointers wrap to 0.
REQ-029 Write X with db_wprev_i=1 after first db_done -> X lands in buffer 0 and is read back at the mapped address.
REQ-030 Ref: write W to addr 4, pulse start_i, ref_ren addr 4 with lane 0..3 -> returns W quarters MSB first. Writes after the toggle do not disturb read data.
REQ-031 rst pulse mid-fill at count=2 -> count_o=0, err_o=0, st_ready_o=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/fetch_db_rot.sv
// fetch_db_rot
// Rotating deblock output buffers feeding a store reader, plus a
// ping-pong reference bank pair.
//
// Buffer ring: the deblock side fills buffer wr_ptr (or the one before it when
// db_wprev_i is set) and closes it with db_done_i. The store side reads buffer
// rd_ptr, two 16-pixel words per 32-pixel access, and releases it with
// st_done_i. count tracks completed-but-undrained buffers; a done pulse that
// cannot be accepted is dropped and latched into err_o.
//
// Ref banks: writes go to bank ref_sel, reads come from the other bank, and
// start_i swaps them. A read returns one 4-pixel lane one cycle later.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   start_i                   pipeline start, swaps ref banks
//   db_wen_i/db_waddr_i/db_wprev_i/db_wdata_i   deblock word write
//   db_done_i, db_full_o      buffer complete / all buffers occupied
//   st_en_i/st_addr_i         store read request (32-pixel word address)
//   st_data_o/st_valid_o      store read data, valid one cycle after request
//   st_ready_o, st_done_i     completed buffer available / oldest drained
//   count_o, err_o            completed-buffer count, sticky {underflow, overflow}
//   ref_wen_i/ref_waddr_i/ref_wdata_i           ref word write
//   ref_ren_i/ref_raddr_i/ref_lane_i/ref_rdata_o ref lane read
module fetch_db_rot #(
  parameter int PIXEL_WIDTH = 8,
  parameter int NUM_BUF     = 3,
  parameter int WADDR_W     = 6,
  parameter int REF_AW      = 5,
  localparam int CW         = $clog2(NUM_BUF + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      db_wen_i,
  input  logic [WADDR_W-1:0]        db_waddr_i,
  input  logic                      db_wprev_i,
  input  logic [16*PIXEL_WIDTH-1:0] db_wdata_i,
  input  logic                      db_done_i,
  output logic                      db_full_o,
  input  logic                      st_en_i,
  input  logic [WADDR_W-2:0]        st_addr_i,
  output logic [32*PIXEL_WIDTH-1:0] st_data_o,
  output logic                      st_valid_o,
  output logic                      st_ready_o,
  input  logic                      st_done_i,
  output logic [CW-1:0]             count_o,
  output logic [1:0]                err_o,
  input  logic                      ref_wen_i,
  input  logic [REF_AW-1:0]         ref_waddr_i,
  input  logic [16*PIXEL_WIDTH-1:0] ref_wdata_i,
  input  logic                      ref_ren_i,
  input  logic [REF_AW-1:0]         ref_raddr_i,
  input  logic [1:0]                ref_lane_i,
  output logic [4*PIXEL_WIDTH-1:0]  ref_rdata_o
);

  localparam int PTR_W = $clog2(NUM_BUF);
  localparam int WW    = 16 * PIXEL_WIDTH;
  localparam int LW    = 4 * PIXEL_WIDTH;
  localparam int BUF_D = 2 ** WADDR_W;
  localparam int REF_D = 2 ** REF_AW;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_BUF - 1);
  localparam logic [CW-1:0]    FULL_CNT = CW'(NUM_BUF);

  logic [WW-1:0]      buf_mem [NUM_BUF][BUF_D];
  logic [WW-1:0]      ref_mem [2][REF_D];

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_tgt;
  logic [CW-1:0]      count;
  logic [1:0]         err;
  logic               ref_sel;
  logic               db_acc;
  logic               st_acc;
  logic               db_wr_ok;
  logic               st_rd_ok;
  logic [WADDR_W-1:0] st_even;
  logic [WADDR_W-1:0] st_odd;
  logic [WW-1:0]      ref_word_q;
  logic [1:0]         ref_lane_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign db_full_o  = (count == FULL_CNT);
  assign st_ready_o = (count != '0);
  assign count_o    = count;
  assign err_o      = err;
  assign st_even    = {st_addr_i, 1'b0};
  assign st_odd     = {st_addr_i, 1'b1};

  always_comb begin
    st_acc = st_done_i && (count != '0);
    // A full ring can still take a done if a buffer drains in the same cycle.
    db_acc = db_done_i && ((count < FULL_CNT) || st_acc);
    wr_tgt = wr_ptr;
    if (db_wprev_i) begin
      wr_tgt = (wr_ptr == '0) ? LAST_PTR : wr_ptr - PTR_W'(1);
    end
    // When full, wr_ptr points at a buffer that still holds undrained data.
    db_wr_ok = db_wen_i && (db_wprev_i || !db_full_o);
    st_rd_ok = st_en_i && st_ready_o;
  end

  always_ff @(posedge clk) begin
    if (db_wr_ok) begin
      buf_mem[wr_tgt][db_waddr_i] <= db_wdata_i;
    end
    if (ref_wen_i) begin
      ref_mem[ref_sel][ref_waddr_i] <= ref_wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err        <= '0;
      ref_sel    <= 1'b0;
      st_valid_o <= 1'b0;
      st_data_o  <= '0;
      ref_word_q <= '0;
      ref_lane_q <= '0;
    end else begin
      if (db_acc) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (st_acc) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({db_acc, st_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (db_done_i && !db_acc) begin
        err[0] <= 1'b1;
      end
      if (st_done_i && !st_acc) begin
        err[1] <= 1'b1;
      end
      st_valid_o <= st_rd_ok;
      if (st_rd_ok) begin
        st_data_o <= {buf_mem[rd_ptr][st_even], buf_mem[rd_ptr][st_odd]};
      end
      // Full word and lane are held together so the output holds between reads.
      if (ref_ren_i) begin
        ref_word_q <= ref_mem[~ref_sel][ref_raddr_i];
        ref_lane_q <= ref_lane_i;
      end
      if (start_i) begin
        ref_sel <= ~ref_sel;
      end
    end
  end

  always_comb begin
    case (ref_lane_q)
      2'd0:    ref_rdata_o = ref_word_q[4*LW-1 -: LW];
      2'd1:    ref_rdata_o = ref_word_q[3*LW-1 -: LW];
      2'd2:    ref_rdata_o = ref_word_q[2*LW-1 -: LW];
      default: ref_rdata_o = ref_word_q[LW-1:0];
    endcase
  end

endmodule
